// File: rtl/hazard_controller_if.sv
// Hazard controller bus: pipeline-side hazard inputs and the enable/flush
// outputs the controller returns.
//   master : pipeline side; drives ID/EX/MEM observations and resume,
//            receives enables, flushes, halted and stall_count.
//   slave  : hazard controller side.
interface hazard_controller_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic [5:0]  id_op_code;
  logic        ex_MemRead;
  logic [4:0]  ex_rt;
  logic        mem_branch_taken;
  logic        resume;
  logic        pc_write;
  logic        if_id_write;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        ex_mem_flush;
  logic        halted;
  logic [15:0] stall_count;

  modport master (
    output id_rs, id_rt, id_uses_rt, id_op_code, ex_MemRead, ex_rt,
           mem_branch_taken, resume,
    input  pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush,
           halted, stall_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_op_code, ex_MemRead, ex_rt,
           mem_branch_taken, resume,
    output pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush,
           halted, stall_count
  );
endinterface

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and a
// HALT sequence that drains the pipeline before stopping.
// Ports:
//   clock : system clock, state updates on rising edge
//   reset : synchronous active-high reset
//   hz    : hazard_controller_if.slave (hazard inputs, enables, flushes,
//           halted flag, saturating load-use stall counter)
//
// state  | meaning
// RUN    | normal issue; stalls on load-use, starts drain on HALT
// DRAIN  | three cycles of bubbles while older instructions retire
// HALTED | pipeline stopped until resume
module hazard_controller (
  input  logic clock,
  input  logic reset,
  hazard_controller_if.slave hz
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [5:0] HALT_OP = 6'b111111;

  state_t      state, state_nxt;
  logic [1:0]  drain_cnt, drain_cnt_nxt;
  logic [15:0] stall_cnt;
  logic        load_use;
  logic        halt_op;
  logic        stall_inc;

  assign load_use = hz.ex_MemRead && (hz.ex_rt != 5'd0) &&
                    ((hz.ex_rt == hz.id_rs) ||
                     (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));
  assign halt_op   = (hz.id_op_code == HALT_OP);
  assign stall_inc = (state == RUN) && !hz.mem_branch_taken && load_use;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= RUN;
      drain_cnt <= 2'd0;
      stall_cnt <= 16'd0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
      if (stall_inc && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    if (hz.mem_branch_taken) begin
      state_nxt     = RUN;
      drain_cnt_nxt = 2'd0;
    end else begin
      case (state)
        RUN: begin
          // A stall takes precedence; the HALT is seen again once it clears.
          if (!load_use && halt_op) begin
            state_nxt     = DRAIN;
            drain_cnt_nxt = 2'd0;
          end
        end
        DRAIN: begin
          if (drain_cnt == 2'd2) begin
            state_nxt     = HALTED;
            drain_cnt_nxt = 2'd0;
          end else begin
            drain_cnt_nxt = drain_cnt + 2'd1;
          end
        end
        HALTED: begin
          if (hz.resume)
            state_nxt = RUN;
        end
        default: begin
          state_nxt     = RUN;
          drain_cnt_nxt = 2'd0;
        end
      endcase
    end
  end

  always_comb begin
    hz.pc_write     = 1'b0;
    hz.if_id_write  = 1'b0;
    hz.if_id_flush  = 1'b0;
    hz.id_ex_flush  = 1'b0;
    hz.ex_mem_flush = 1'b0;
    hz.halted       = 1'b0;
    hz.stall_count  = stall_cnt;
    if (reset) begin
      hz.if_id_flush  = 1'b1;
      hz.id_ex_flush  = 1'b1;
      hz.ex_mem_flush = 1'b1;
    end else begin
      hz.halted = (state == HALTED);
      if (hz.mem_branch_taken) begin
        hz.pc_write     = 1'b1;
        hz.if_id_write  = 1'b1;
        hz.if_id_flush  = 1'b1;
        hz.id_ex_flush  = 1'b1;
        hz.ex_mem_flush = 1'b1;
      end else begin
        case (state)
          RUN: begin
            if (load_use || halt_op) begin
              hz.id_ex_flush = 1'b1;
            end else begin
              hz.pc_write    = 1'b1;
              hz.if_id_write = 1'b1;
            end
          end
          HALTED: begin
            hz.id_ex_flush = 1'b1;
            if (hz.resume) begin
              // Fetch restarts; the HALT still sitting in IF/ID is discarded.
              hz.pc_write    = 1'b1;
              hz.if_id_write = 1'b1;
              hz.if_id_flush = 1'b1;
            end
          end
          default: hz.id_ex_flush = 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
module tb_hazard_controller;
  logic clock;
  logic reset;
  hazard_controller_if hz();

  hazard_controller dut (
    .clock (clock),
    .reset (reset),
    .hz    (hz)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: halted flag, remaining drain bubbles, stall total.
  bit m_halted;
  int m_drain;
  int m_stalls;

  logic [5:0] obs;
  logic [5:0] exp_o;
  assign obs = {hz.pc_write, hz.if_id_write, hz.if_id_flush,
                hz.id_ex_flush, hz.ex_mem_flush, hz.halted};

  function automatic bit m_hazard();
    return hz.ex_MemRead && hz.ex_rt != 0 &&
           (hz.ex_rt == hz.id_rs || (hz.id_uses_rt && hz.ex_rt == hz.id_rt));
  endfunction

  // {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, halted}
  function automatic logic [5:0] model_out();
    if (reset)                return 6'b001110;
    if (hz.mem_branch_taken)  return {5'b11111, m_halted};
    if (m_halted)             return hz.resume ? 6'b111101 : 6'b000101;
    if (m_drain > 0)          return 6'b000100;
    if (m_hazard() || hz.id_op_code == 6'h3F) return 6'b000100;
    return 6'b110000;
  endfunction

  task automatic model_step();
    if (reset) begin
      m_halted = 0; m_drain = 0; m_stalls = 0;
    end else if (hz.mem_branch_taken) begin
      m_halted = 0; m_drain = 0;
    end else if (m_halted) begin
      if (hz.resume) m_halted = 0;
    end else if (m_drain > 0) begin
      m_drain--;
      if (m_drain == 0) m_halted = 1;
    end else if (m_hazard()) begin
      if (m_stalls < 65535) m_stalls++;
    end else if (hz.id_op_code == 6'h3F) begin
      m_drain = 3;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic idle();
    reset = 0;
    hz.id_rs = 0; hz.id_rt = 0; hz.id_uses_rt = 0; hz.id_op_code = 0;
    hz.ex_MemRead = 0; hz.ex_rt = 0; hz.mem_branch_taken = 0; hz.resume = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    hz.mem_branch_taken = 1; hz.resume = 1; hz.id_op_code = 6'h3F;
    tick();
    #3;
    n_checks++;
    if (obs !== 6'b001110 || hz.stall_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_outs: got %b/%0d want 001110/0", obs, hz.stall_count);
    end
    idle();
    tick();
    #3;
    n_checks++;
    if (obs !== 6'b110000 || hz.stall_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_idle: got %b/%0d want 110000/0", obs, hz.stall_count);
    end
  endtask

  // Cases: rs match, rs match with rt=0, rt match gated by id_uses_rt.
  task automatic test_load_use();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      idle();
      case (c)
        1: begin hz.ex_MemRead = 1; hz.ex_rt = 5; hz.id_rs = 5; end
        3: begin hz.ex_MemRead = 1; hz.ex_rt = 0; hz.id_rs = 0; end
        5: begin hz.ex_MemRead = 1; hz.ex_rt = 7; hz.id_rt = 7; hz.id_rs = 3; end
        6: begin hz.ex_MemRead = 1; hz.ex_rt = 7; hz.id_rt = 7; hz.id_rs = 3;
                 hz.id_uses_rt = 1; end
        default: ;
      endcase
      #3;
      exp_o = model_out();
      n_checks++;
      if (obs !== exp_o || hz.stall_count !== 16'(m_stalls)) begin
        n_fail++;
        $display("FAIL load_use c%0d: got %b/%0d want %b/%0d", c, obs,
                 hz.stall_count, exp_o, m_stalls);
      end
      tick();
    end
    n_checks++;
    if (hz.stall_count !== 16'd2) begin
      n_fail++;
      $display("FAIL load_use_total: got %0d want 2", hz.stall_count);
    end
  endtask

  task automatic test_halt_resume();
    do_reset();
    for (int c = 0; c < 9; c++) begin
      idle();
      if (c <= 5) hz.id_op_code = 6'h3F;
      if (c == 5) hz.resume = 1;
      if (c == 2) hz.resume = 1;  // ignored while draining
      #3;
      exp_o = model_out();
      n_checks++;
      if (obs !== exp_o) begin
        n_fail++;
        $display("FAIL halt_resume c%0d: got %b want %b", c, obs, exp_o);
      end
      if (c == 4) begin
        n_checks++;
        if (hz.halted !== 1'b1) begin
          n_fail++;
          $display("FAIL halt_after_3_drain: got %b want 1", hz.halted);
        end
      end
      tick();
    end
  endtask

  task automatic test_branch_in_drain();
    do_reset();
    for (int c = 0; c < 7; c++) begin
      idle();
      if (c == 0) hz.id_op_code = 6'h3F;
      if (c == 2) hz.mem_branch_taken = 1;
      #3;
      exp_o = model_out();
      n_checks++;
      if (obs !== exp_o || hz.halted !== 1'b0) begin
        n_fail++;
        $display("FAIL branch_in_drain c%0d: got %b want %b", c, obs, exp_o);
      end
      tick();
    end
  endtask

  task automatic test_stall_then_halt();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      idle();
      hz.id_op_code = (c < 2) ? 6'h3F : 6'h00;
      if (c == 0) begin hz.ex_MemRead = 1; hz.ex_rt = 9; hz.id_rs = 9; end
      #3;
      exp_o = model_out();
      n_checks++;
      if (obs !== exp_o || hz.stall_count !== 16'(m_stalls)) begin
        n_fail++;
        $display("FAIL stall_then_halt c%0d: got %b/%0d want %b/%0d", c, obs,
                 hz.stall_count, exp_o, m_stalls);
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    do_reset();
    idle();
    hz.ex_MemRead = 1; hz.ex_rt = 4; hz.id_rs = 4;
    for (int c = 0; c < 65538; c++) tick();
    #3;
    n_checks++;
    if (hz.stall_count !== 16'hFFFF || m_stalls != 65535) begin
      n_fail++;
      $display("FAIL saturation: got %h want ffff", hz.stall_count);
    end
    tick();
    #3;
    n_checks++;
    if (hz.stall_count !== 16'hFFFF || obs !== 6'b000100) begin
      n_fail++;
      $display("FAIL saturation_hold: got %h/%b want ffff/000100", hz.stall_count, obs);
    end
  endtask

  task automatic test_reset_in_halted();
    do_reset();
    idle();
    hz.ex_MemRead = 1; hz.ex_rt = 2; hz.id_rs = 2;
    for (int c = 0; c < 42; c++) tick();
    idle();
    hz.id_op_code = 6'h3F;
    for (int c = 0; c < 5; c++) tick();
    #3;
    n_checks++;
    if (hz.halted !== 1'b1 || hz.stall_count !== 16'd42) begin
      n_fail++;
      $display("FAIL pre_reset_halted: got %b/%0d want 1/42", hz.halted, hz.stall_count);
    end
    reset = 1;
    tick();
    reset = 0;
    hz.id_op_code = 6'h00;
    #3;
    n_checks++;
    if (obs !== 6'b110000 || hz.stall_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_in_halted: got %b/%0d want 110000/0", obs, hz.stall_count);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      idle();
      reset               = ($urandom_range(0, 49) == 0);
      hz.id_rs            = 5'($urandom_range(0, 3));
      hz.id_rt            = 5'($urandom_range(0, 3));
      hz.id_uses_rt       = 1'($urandom_range(0, 1));
      hz.ex_MemRead       = 1'($urandom_range(0, 1));
      hz.ex_rt            = 5'($urandom_range(0, 3));
      hz.id_op_code       = ($urandom_range(0, 5) == 0) ? 6'h3F : 6'($urandom_range(0, 62));
      hz.mem_branch_taken = ($urandom_range(0, 15) == 0);
      hz.resume           = ($urandom_range(0, 3) == 0);
      #3;
      exp_o = model_out();
      n_checks++;
      if (obs !== exp_o || hz.stall_count !== 16'(m_stalls)) begin
        n_fail++;
        $display("FAIL random c%0d: got %b/%0d want %b/%0d", c, obs,
                 hz.stall_count, exp_o, m_stalls);
      end
      tick();
    end
  endtask

  initial begin
    m_halted = 0; m_drain = 0; m_stalls = 0;
    idle();
    #1;
    test_reset();
    test_load_use();
    test_halt_resume();
    test_branch_in_drain();
    test_stall_then_halt();
    test_reset_in_halted();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
